// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single shared memory bus.
// Each transaction is one ACCESS cycle (strobe) followed by one RESP cycle (ack).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_read,
    output logic              mem_write
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                win_valid;
    logic                win_port;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        mem_address_d = mem_address_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        win_valid     = 1'b0;
        win_port      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (req0 && req1) begin
                    win_valid = 1'b1;
                    win_port  = ~last_grant_q;
                end else if (req0 || req1) begin
                    win_valid = 1'b1;
                    win_port  = req1;
                end
            end
            ACCESS: begin
                state_d      = RESP;
                last_grant_d = gnt_q;
                if (gnt_q) ack1_d = 1'b1;
                else       ack0_d = 1'b1;
                if (!we_q) begin
                    if (gnt_q) rdata1_d = mem_data;
                    else       rdata0_d = mem_data;
                end
            end
            RESP: begin
                // The port just served is excluded; only the other one can win here.
                state_d = IDLE;
                if (gnt_q ? req0 : req1) begin
                    win_valid = 1'b1;
                    win_port  = ~gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (win_valid) begin
            state_d       = ACCESS;
            gnt_d         = win_port;
            we_d          = win_port ? we1 : we0;
            wdata_d       = win_port ? wdata1 : wdata0;
            mem_address_d = win_port ? addr1 : addr0;
            mem_read_d    = ~(win_port ? we1 : we0);
            mem_write_d   = win_port ? we1 : we0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_data    = mem_write_q ? wdata_q : 'z;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width of both requester ports and of the memory port.
REQ-002 Parameter: DATA_W, 16, data width of both requester ports and of the memory port.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0 / req1  input  1  access request from port 0 (CPU control unit) / port 1 (IO/DMA).
REQ-006 we0 / we1  input  1  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0 / addr1  input  ADDR_W  access address; qualified by reqN.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; qualified by reqN and weN.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to port 0 / port 1.
REQ-010 rdata0 / rdata1  output  DATA_W  read data, valid in the ackN cycle and held until that port's next read completes.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mem_address  output  ADDR_W  address to shared memory.
REQ-013 mem_data  inout  DATA_W  shared memory data bus.
REQ-014 mem_read / mem_write  output  1  memory read / write strobes; registered outputs.

Function
REQ-015 Three states: IDLE, ACCESS, RESP; the state register and all outputs are registered.
REQ-016 In IDLE, any asserted reqN causes the next state to be ACCESS. The winning port, its we, addr and wdata are latched at that edge.
REQ-017 Arbitration is round-robin. A last_grant register records the last granted port. When both requests are asserted, the port that is not last_grant wins. When only one request is asserted, that port wins.
REQ-018 During ACCESS:
- mem_address = latched addr.
- mem_read = !latched we.
- mem_write = latched we.
- mem_read and mem_write are never high together.
REQ-019 mem_data is driven with latched wdata only while mem_write = 1; otherwise it is high-Z.
REQ-020 At the ACCESS-to-RESP edge:
- for a read, mem_data is captured into rdataN of the granted port;
- last_grant is updated to the granted port;
- mem_read and mem_write return to 0.
REQ-021 In RESP, ackN of the granted port = 1 for exactly one cycle. The other port's ack stays 0.
REQ-022 RESP arbitrates exactly like IDLE, except that the just-served port is excluded at that edge. Next state is ACCESS if the other port requests, otherwise IDLE.
REQ-023 Latency: a request sampled at edge E produces the memory strobe in cycle E..E+1 and ackN in cycle E+1..E+2. Back-to-back alternating service takes 2 cycles per transaction.
REQ-024 A requester holds reqN and its qualifiers stable until it sees ackN, and drops reqN in the cycle after ackN unless it issues a new request. Changes to the qualifiers after the grant edge have no effect on the current transaction.
REQ-025 Deasserting reqN after it has been granted does not abort the transaction; ackN is still issued.
REQ-026 Writes from one port do not alter the rdata register of either port.

Reset
REQ-027 While reset = 0, the following take effect immediately and independently of clk:
- state = IDLE;
- ack0 = ack1 = 0;
- mem_read = mem_write = 0;
- mem_address = 0;
- rdata0 = rdata1 = 0;
- busy = 0;
- mem_data = high-Z;
- last_grant = 1, so port 0 wins the first tie.
REQ-028 A reset asserted during ACCESS or RESP abandons the transaction: no ack is produced and the strobes drop immediately. The requester re-requests after reset is released.
REQ-029 The first arbitration is on the first rising edge after reset rises.

Verification
REQ-030 Single read: mem[0x010] = 0xBEEF; req0 = 1, we0 = 0, addr0 = 0x010.
-> mem_read = 1 with mem_address = 0x010 for one cycle, then ack0 = 1 with rdata0 = 0xBEEF. ack1 stays 0.
REQ-031 Single write: req1 = 1, we1 = 1, addr1 = 0x020, wdata1 = 0x1234.
-> mem_write = 1 for one cycle with mem_data = 0x1234, then ack1.
-> A subsequent port-0 read of 0x020 returns 0x1234.
REQ-032 Simultaneous requests right after reset, both held.
-> Grant order 0, 1, 0, 1 with ack spacing of 2 cycles.
-> mem_read and mem_write are never both 1.
-> mem_data is Z in every non-write cycle.
REQ-033 Port 0 requests continuously, then port 1 raises req1 while port 0 is in ACCESS.
-> Port 1 is served next, before port 0's second access (no starvation).
REQ-034 Reset pulled low during ACCESS of a write to 0x030.
-> Strobes drop asynchronously and no ack is produced.
-> After reset is released, the state is IDLE and busy = 0.
REQ-035 req0 dropped one cycle after the grant.
-> ack0 is still produced and rdata0 is updated.
